// File: rtl/chan_readout_framer.sv
// chan_readout_framer
// Frames the 12-bit samples from one readout channel into 16-bit words for the
// SPI slave. Each frame is a header, the samples, then a trailer. The words are
// written to a small FIFO with a registered first-word-fall-through output.
// The channel cannot be stalled, so a sample that finds the FIFO full is
// dropped and flagged instead.
//
// Ports
//   clk, reset_n      system clock, synchronous active-low reset
//   start, how_many   readout start pulse and requested sample count
//   sample_in/_valid  channel data and its strobe
//   ro_enable         channel readout enable; a falling edge ends the frame
//   out_data/_valid   FIFO head word and not-empty flag
//   out_ready         consumer takes out_data when out_valid is also high
//   busy              frame in progress (any state but IDLE)
//   overflow          at least one sample dropped in the current frame
//   fifo_level        words currently held in the FIFO
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// HDR   | header pending, pushed as soon as there is room
// DATA  | taking samples until how_many received or ro_enable falls
// TRL   | trailer pending, pushed as soon as there is room
module chan_readout_framer #(
  parameter int         SIZE       = 12,
  parameter int         WIDTH      = 12,
  parameter logic [3:0] CHAN_ID    = 4'h0,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [SIZE-1:0]       how_many,
  input  logic [WIDTH-1:0]      sample_in,
  input  logic                  sample_valid,
  input  logic                  ro_enable,
  output logic [15:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_TRL} state_t;

  state_t state_q, state_d;

  logic [SIZE-1:0] hm_q;
  logic [SIZE-1:0] cnt_q;
  logic [SIZE-1:0] rcv_q;
  logic [7:0]      seq_q;
  logic            ovf_q;
  logic            ro_q;
  logic            busy_q;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LW-1:0]         level_q;
  logic [15:0]           head_q;

  logic            pop;
  logic            full;
  logic            space;
  logic            ro_fall;
  logic [SIZE:0]   rcv_next;
  logic            last_sample;

  // FSM outputs
  logic            push;
  logic [15:0]     push_word;
  logic            frame_start;
  logic            cnt_inc;
  logic            rcv_inc;
  logic            ovf_set;
  logic            seq_inc;

  // FIFO next-head helpers
  logic [LW-1:0]         lvl_after_pop;
  logic [DEPTH_LOG2-1:0] rd_next;
  logic [15:0]           head_next;

  assign pop   = (level_q != '0) && out_ready;
  assign full  = (level_q == LW'(DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign space = !full || pop;

  assign ro_fall     = ro_q && !ro_enable;
  assign rcv_next    = {1'b0, rcv_q} + (SIZE+1)'(1);
  assign last_sample = sample_valid && (rcv_next == {1'b0, hm_q});

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_HDR;
      S_HDR:  if (space) state_d = S_DATA;
      S_DATA: begin
        if (hm_q == '0)                  state_d = S_TRL;
        else if (last_sample || ro_fall) state_d = S_TRL;
      end
      S_TRL:  if (space) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    push        = 1'b0;
    push_word   = 16'h0000;
    frame_start = 1'b0;
    cnt_inc     = 1'b0;
    rcv_inc     = 1'b0;
    ovf_set     = 1'b0;
    seq_inc     = 1'b0;
    case (state_q)
      S_IDLE: frame_start = start;
      S_HDR: begin
        if (space) begin
          push      = 1'b1;
          push_word = {4'hA, CHAN_ID, seq_q};
        end
        if (sample_valid) ovf_set = 1'b1;
      end
      S_DATA: begin
        // With a zero-length request the frame closes without taking samples.
        if ((hm_q != '0) && sample_valid) begin
          rcv_inc = 1'b1;
          if (space) begin
            push      = 1'b1;
            push_word = {4'h0, 12'(sample_in)};
            cnt_inc   = 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      S_TRL: begin
        if (space) begin
          push      = 1'b1;
          push_word = {3'b111, ovf_q, 12'(cnt_q)};
          seq_inc   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Frame bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hm_q   <= '0;
      cnt_q  <= '0;
      rcv_q  <= '0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
      ro_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ro_q   <= ro_enable;
      busy_q <= (state_d != S_IDLE);
      if (frame_start) begin
        hm_q  <= how_many;
        cnt_q <= '0;
        rcv_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (cnt_inc) cnt_q <= cnt_q + SIZE'(1);
        if (rcv_inc) rcv_q <= rcv_q + SIZE'(1);
        if (ovf_set) ovf_q <= 1'b1;
      end
      if (seq_inc) seq_q <= seq_q + 8'd1;
    end
  end

  // FIFO storage (contents need no reset; pointers and level gate every read)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // The head register is loaded with whatever will be at the read pointer
  // after this cycle's pop; when the pop empties the FIFO, that is the word
  // being pushed right now.
  assign lvl_after_pop = level_q - LW'(pop);
  assign rd_next       = rd_ptr + DEPTH_LOG2'(pop);
  assign head_next     = (lvl_after_pop == '0) ? push_word : mem[rd_next];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      head_q  <= 16'h0000;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if ((lvl_after_pop != '0) || push) head_q <= head_next;
    end
  end

  assign out_data   = head_q;
  assign out_valid  = (level_q != '0);
  assign fifo_level = level_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;

endmodule
